// File: rtl/tow_round_ctrl.sv
// Tug-of-war round sequencer: gathers random bits into a start delay, times
// it, raises go, and judges false starts and the first valid press.
module tow_round_ctrl #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned NBITS    = 4,
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned MIN_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rbit,
    input  logic             btn_l,
    input  logic             btn_r,
    output logic             lfsr_step,
    output logic             busy,
    output logic             go,
    output logic [NBITS-1:0] wait_val,
    output logic             early_l,
    output logic             early_r,
    output logic             hit_l,
    output logic             hit_r
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = $clog2(NBITS + 1);
    localparam int unsigned UW = NBITS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        WAIT   = 2'd2,
        GO     = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    div, div_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic [NBITS-1:0] sh, sh_n;
    logic [NBITS-1:0] wait_val_n;
    logic [UW-1:0]    units, units_n;
    logic [TW-1:0]    tick, tick_n;
    logic             lfsr_step_n, busy_n, go_n;
    logic             early_l_n, early_r_n, hit_l_n, hit_r_n;
    logic             press;

    assign press = btn_l | btn_r;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            bcnt      <= '0;
            sh        <= '0;
            wait_val  <= '0;
            units     <= '0;
            tick      <= '0;
            lfsr_step <= 1'b0;
            busy      <= 1'b0;
            go        <= 1'b0;
            early_l   <= 1'b0;
            early_r   <= 1'b0;
            hit_l     <= 1'b0;
            hit_r     <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            bcnt      <= bcnt_n;
            sh        <= sh_n;
            wait_val  <= wait_val_n;
            units     <= units_n;
            tick      <= tick_n;
            lfsr_step <= lfsr_step_n;
            busy      <= busy_n;
            go        <= go_n;
            early_l   <= early_l_n;
            early_r   <= early_r_n;
            hit_l     <= hit_l_n;
            hit_r     <= hit_r_n;
        end
    end

    // Next-state and next-output logic; a press in GATHER/WAIT always wins
    always_comb begin
        state_n     = state;
        div_n       = div;
        bcnt_n      = bcnt;
        sh_n        = sh;
        wait_val_n  = wait_val;
        units_n     = units;
        tick_n      = tick;
        lfsr_step_n = 1'b0;
        early_l_n   = 1'b0;
        early_r_n   = 1'b0;
        hit_l_n     = 1'b0;
        hit_r_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = GATHER;
                    div_n   = '0;
                    bcnt_n  = '0;
                    sh_n    = '0;
                end
            end
            GATHER: begin
                if (press) begin
                    early_l_n = btn_l;
                    early_r_n = btn_r;
                    state_n   = IDLE;
                end else if (div == DW'(CLK_DIV - 1)) begin
                    div_n       = '0;
                    sh_n        = NBITS'({sh, rbit});
                    bcnt_n      = BW'(bcnt + 1'b1);
                    lfsr_step_n = 1'b1;
                    if (bcnt == BW'(NBITS - 1)) begin
                        wait_val_n = sh_n;
                        units_n    = UW'(sh_n) + UW'(MIN_WAIT);
                        tick_n     = '0;
                        state_n    = WAIT;
                    end
                end else begin
                    div_n = DW'(div + 1'b1);
                end
            end
            WAIT: begin
                if (press) begin
                    early_l_n = btn_l;
                    early_r_n = btn_r;
                    state_n   = IDLE;
                end else if (tick == TW'(TICK_DIV - 1)) begin
                    tick_n = '0;
                    if (units == UW'(1)) begin
                        state_n = GO;
                    end else begin
                        units_n = UW'(units - 1'b1);
                    end
                end else begin
                    tick_n = TW'(tick + 1'b1);
                end
            end
            GO: begin
                if (press) begin
                    hit_l_n = btn_l;
                    hit_r_n = btn_r;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        go_n   = (state_n == GO);
    end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Bench for tow_round_ctrl: timeline-based reference model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_tow_round_ctrl;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned NBITS    = 4;
    localparam int unsigned TICK_DIV = 8;
    localparam int unsigned MIN_WAIT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             rbit = 1'b0;
    logic             btn_l = 1'b0;
    logic             btn_r = 1'b0;
    logic             lfsr_step, busy, go, early_l, early_r, hit_l, hit_r;
    logic [NBITS-1:0] wait_val;

    always #5 clk = ~clk;

    tow_round_ctrl #(
        .CLK_DIV (CLK_DIV),
        .NBITS   (NBITS),
        .TICK_DIV(TICK_DIV),
        .MIN_WAIT(MIN_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rbit     (rbit),
        .btn_l    (btn_l),
        .btn_r    (btn_r),
        .lfsr_step(lfsr_step),
        .busy     (busy),
        .go       (go),
        .wait_val (wait_val),
        .early_l  (early_l),
        .early_r  (early_r),
        .hit_l    (hit_l),
        .hit_r    (hit_r)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0 = 0;

    // Reference model: phase plus absolute edge times since the start edge
    int               m_phase = 0;   // 0 idle, 1 gather, 2 wait, 3 go
    int               m_t = 0;
    int               m_acc = 0;
    int               m_go_at = 0;
    logic [NBITS-1:0] m_wv = '0;
    logic             m_step = 0, m_busy = 0, m_go = 0;
    logic             m_el = 0, m_er = 0, m_hl = 0, m_hr = 0;
    bit               m_valid = 0;

    always @(posedge clk) begin
        cyc++;
        m_step = 0; m_el = 0; m_er = 0; m_hl = 0; m_hr = 0;
        if (rst) begin
            m_phase = 0;
            m_wv    = '0;
            m_valid = 1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_t = 0; m_acc = 0; e0 = cyc;
                end
                1: begin
                    m_t++;
                    if (btn_l || btn_r) begin
                        m_el = btn_l; m_er = btn_r; m_phase = 0;
                    end else if (m_t % CLK_DIV == 0) begin
                        m_acc  = m_acc * 2 + int'(rbit);
                        m_step = 1;
                        if (m_t == NBITS * CLK_DIV) begin
                            m_wv    = NBITS'(m_acc);
                            m_go_at = m_t + (int'(m_wv) + MIN_WAIT) * TICK_DIV;
                            m_phase = 2;
                        end
                    end
                end
                2: begin
                    m_t++;
                    if (btn_l || btn_r) begin
                        m_el = btn_l; m_er = btn_r; m_phase = 0;
                    end else if (m_t == m_go_at) begin
                        m_phase = 3;
                    end
                end
                default: if (btn_l || btn_r) begin
                    m_hl = btn_l; m_hr = btn_r; m_phase = 0;
                end
            endcase
        end
        m_busy = (m_phase != 0);
        m_go   = (m_phase == 3);
    end

    // Random generator stand-in: pattern bit k (MSB first) ahead of sample k
    logic [NBITS-1:0] rpat = '0;
    always @(posedge clk) begin
        int idx;
        #2;
        idx = (cyc - e0) / CLK_DIV;
        rbit = (idx >= 0 && idx < NBITS) ? rpat[NBITS-1-idx] : 1'b0;
    end

    // Per-cycle compare plus event timestamps relative to the start edge
    int   go_rise = -1, step_cnt = 0, first_step = -1, last_step = -1;
    int   hit_l_at = -1, hit_r_at = -1, early_l_at = -1, early_r_at = -1;
    logic prev_go = 1'b0;

    always @(negedge clk) begin
        logic [NBITS+6:0] got, exp;
        if (m_valid) begin
            got = {lfsr_step, busy, go, early_l, early_r, hit_l, hit_r, wait_val};
            exp = {m_step, m_busy, m_go, m_el, m_er, m_hl, m_hr, m_wv};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cycle_cmp cyc=%0d rel=%0d got=%h exp=%h (step,busy,go,el,er,hl,hr,wv)",
                         cyc, cyc - e0, got, exp);
            end
            if (go === 1'b1 && prev_go !== 1'b1) go_rise = cyc - e0;
            prev_go = go;
            if (lfsr_step === 1'b1) begin
                step_cnt++;
                if (first_step < 0) first_step = cyc - e0;
                last_step = cyc - e0;
            end
            if (hit_l === 1'b1)   hit_l_at   = cyc - e0;
            if (hit_r === 1'b1)   hit_r_at   = cyc - e0;
            if (early_l === 1'b1) early_l_at = cyc - e0;
            if (early_r === 1'b1) early_r_at = cyc - e0;
        end
    end

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endfunction

    task automatic clear_events();
        go_rise = -1; step_cnt = 0; first_step = -1; last_step = -1;
        hit_l_at = -1; hit_r_at = -1; early_l_at = -1; early_r_at = -1;
    endtask

    // Leaves the bench 2 time units after edge E0
    task automatic start_round(input logic [NBITS-1:0] pat);
        rpat = pat;
        clear_events();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Returns just after edge E(k-1) so the next drive is sampled at E(k)
    task automatic wait_edge(input int k);
        int guard = 0;
        while ((cyc - e0) < k - 1 && guard < 2000) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 2000) begin
            failures++;
            $display("FAIL wait_edge_timeout k=%0d rel=%0d", k, cyc - e0);
        end
    endtask

    task automatic press_at(input int k, input logic l, input logic r);
        wait_edge(k);
        btn_l = l; btn_r = r;
        @(posedge clk); #2;
        btn_l = 1'b0; btn_r = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        int base;
        // 1. Reset dominates start and buttons
        rst = 1'b1; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            btn_l = (i % 2 == 0); btn_r = (i % 2 == 1);
        end
        check("reset_no_step", step_cnt, 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        idle(2);
        check("idle_after_reset", int'(busy), 0);

        // 2. Nominal round, pattern 1,0,1,1
        start_round(4'b1011);
        press_at(130, 1'b0, 1'b1);
        check("nom_wait_val", int'(wait_val), 11);
        check("nom_go_rise", go_rise, 120);
        check("nom_step_cnt", step_cnt, 4);
        check("nom_first_step", first_step, 4);
        check("nom_last_step", last_step, 16);
        check("nom_hit_r", hit_r_at, 130);
        check("nom_hit_l", hit_l_at, -1);
        check("nom_busy_low", int'(busy), 0);

        // 3. Delay extremes
        start_round(4'b0000);
        press_at(40, 1'b1, 1'b0);
        check("min_wait_val", int'(wait_val), 0);
        check("min_go_rise", go_rise, 32);
        check("min_hit_l", hit_l_at, 40);
        start_round(4'b1111);
        press_at(160, 1'b1, 1'b1);
        check("max_wait_val", int'(wait_val), 15);
        check("max_go_rise", go_rise, 152);
        check("max_hit_l", hit_l_at, 160);
        check("max_hit_r", hit_r_at, 160);

        // 4a. False start in WAIT
        start_round(4'b1011);
        press_at(50, 1'b1, 1'b0);
        wait_edge(140);
        check("fs_wait_early_l", early_l_at, 50);
        check("fs_wait_early_r", early_r_at, -1);
        check("fs_wait_no_go", go_rise, -1);
        check("fs_wait_val_held", int'(wait_val), 11);
        // 4b. Both press in GATHER; wait_val keeps the previous round's value
        start_round(4'b0110);
        press_at(6, 1'b1, 1'b1);
        check("fs_gather_early_l", early_l_at, 6);
        check("fs_gather_early_r", early_r_at, 6);
        check("fs_gather_steps", step_cnt, 1);
        check("fs_gather_val_held", int'(wait_val), 11);
        // 4c. Press on the would-be GO edge
        start_round(4'b1011);
        press_at(120, 1'b0, 1'b1);
        idle(5);
        check("fs_edge_early_r", early_r_at, 120);
        check("fs_edge_no_hit", hit_r_at, -1);
        check("fs_edge_no_go", go_rise, -1);

        // 5. Tie in GO with start held high throughout
        rpat = 4'b0000;
        clear_events();
        start = 1'b1;
        @(posedge clk); #2;
        base = e0;
        press_at(40, 1'b1, 1'b1);
        check("tie_hit_l", hit_l_at, 40);
        check("tie_hit_r", hit_r_at, 40);
        check("tie_restart_edge", e0 - base, 41);
        start = 1'b0;

        // 6. Reset during WAIT, then during GATHER
        clear_events();
        wait_edge(20);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        idle(50);
        check("rst_wait_no_go", go_rise, -1);
        check("rst_wait_val", int'(wait_val), 0);
        start_round(4'b1011);
        wait_edge(8);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        idle(40);
        check("rst_gather_steps", step_cnt, 1);
        check("rst_gather_no_go", go_rise, -1);
        check("rst_gather_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tow_round_ctrl.md
# tow_round_ctrl

Round sequencer for the tug-of-war game. It drives the step enable of the 10-bit random bit generator and collects NBITS serial random bits into a random start delay. It then times that delay, raises `go`, and judges false starts and the first valid press from each player. It sits between the debounced player buttons, the random generator and the rope/score logic, which consumes its `hit_*` and `early_*` pulses.

## Interface
Parameters:
- CLK_DIV, default 4: clk cycles per random-bit step; must be at least 2.
- NBITS, default 4: number of random bits gathered per round.
- TICK_DIV, default 8: clk cycles per delay unit; must be at least 1.
- MIN_WAIT, default 2: delay units added to the random value; range 1..2^NBITS.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; a new round is requested when sampled high in IDLE.
- rbit  in  1  serial output of the random generator.
- btn_l  in  1  left player press, one-cycle pulse, already debounced.
- btn_r  in  1  right player press, one-cycle pulse, already debounced.
- lfsr_step  out  1  registered one-cycle pulse; drives the generator's step enable.
- busy  out  1  registered; high whenever state is not IDLE.
- go  out  1  registered level; high only in GO.
- wait_val  out  NBITS  random value latched for the current round.
- early_l, early_r  out  1  one-cycle false-start pulses.
- hit_l, hit_r  out  1  one-cycle valid-press pulses.

## Operation
States are IDLE, GATHER, WAIT and GO.

Reset:
- rst=1 forces IDLE.
- All outputs are 0, wait_val is 0, and all counters and the shift register are 0.
- Overrides every other input.
- The generator has its own reset; this block never resets it.

IDLE:
- btn_l and btn_r are ignored.
- start=1 moves to GATHER and clears the divider `div`, the bit count and the shift register `sh`.

GATHER:
- `div` counts 0..CLK_DIV-1.
- On the edge with div==CLK_DIV-1: shift rbit in with `sh` <= {sh[NBITS-2:0], rbit} (first bit ends as MSB), increment the bit count, and set lfsr_step=1 for the following cycle.
- rbit is therefore sampled at least CLK_DIV-1 cycles after the previous step, so it is stable.
- On the NBITS-th sample edge: load wait_val with the new sh value, load units (NBITS+1 bits) with wait_val+MIN_WAIT, clear `tick`, and go to WAIT.

WAIT:
- `tick` counts 0..TICK_DIV-1.
- On an edge with tick==TICK_DIV-1: if units==1, go to GO; otherwise decrement units.

False starts:
- Any btn_l or btn_r in GATHER or WAIT pulses early_l and/or early_r (both if both are pressed) and aborts to IDLE.
- wait_val holds its value after an abort.
- A press on the same edge that would enter GO counts as early.

GO:
- go=1.
- The first edge with any press pulses hit_l and/or hit_r (both on a tie), then moves to IDLE with go=0.
- go stays high indefinitely until a press.

Other rules:
- start while busy=1 is ignored.
- lfsr_step is only ever asserted because of a GATHER sample.

## Timing
- Latency is counted from edge E0, where start is sampled high in IDLE.
- busy=1 from E0.
- The k-th sample occurs at E(k·CLK_DIV). lfsr_step is high in the cycle after each sample edge, so exactly NBITS pulses occur per completed GATHER.
- WAIT is entered at E(NBITS·CLK_DIV).
- go rises at E(NBITS·CLK_DIV + (wait_val+MIN_WAIT)·TICK_DIV).
- early_*, hit_* and the IDLE transition are registered one edge after the press is sampled; those pulses last exactly one cycle.
- go and busy fall on that same edge.
- A new start is accepted on the first edge at which the state is IDLE.

## Test plan
Defaults apply throughout.

1. Reset: hold rst with start=1 and pulsing buttons -> all outputs 0, no lfsr_step. Release -> state IDLE, and a round starts from the next start.
2. Nominal round: start at E0 with rbit sequence 1,0,1,1 -> lfsr_step high in the cycles after E4, E8, E12 and E16; wait_val=4'b1011; go rises at E120. Then btn_r at E130 -> hit_r for one cycle, go and busy fall, hit_l stays 0.
3. Delay extremes: rbit always 0 -> wait_val=0, go at E32. rbit always 1 -> wait_val=15, go at E152.
4. False starts:
   - btn_l in WAIT at E50 -> early_l for one cycle, IDLE, go never rises.
   - btn_l and btn_r together in GATHER -> both early pulses.
   - A press on the edge that would enter GO -> early, not hit.
5. Contention: btn_l and btn_r on the same cycle in GO -> hit_l and hit_r both pulse. start held high through the round -> no restart until IDLE, then a new round begins on the next edge.
6. Reset mid-round: rst asserted during WAIT and again during GATHER -> IDLE on the next edge, no further lfsr_step, go stays 0.
